// File: rtl/cbus_line_master.sv
// cbus_line_master: turns one cache-line fill or writeback into a single CBus burst.
// Define CBUS_LINE_CWF_EN for critical-word-first (WRAP) fills with a crit_valid/crit_data tap.
package cbus_pkg;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] BURST_WRAP = 2'd2;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_line_master
  import cbus_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [LINE_WORDS*64-1:0]   cmd_wline,
  output logic [LINE_WORDS*64-1:0]   rline,
  output logic                       done,
  output logic                       crit_valid,
  output logic [63:0]                crit_data,
  output cbus_req_t                  creq,
  input  cbus_resp_t                 cresp
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int OFS = IW + 3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS*8-1);
  logic [1:0] state;
  logic [IW-1:0] beat;
  logic [IW-1:0] start_idx;
  logic wr;
  logic accept;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_WORDS-1:0][63:0] wline;
  logic [LINE_WORDS-1:0][63:0] rbuf;
`ifdef CBUS_LINE_CWF_EN
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(7);
  localparam logic [1:0] RD_BURST = BURST_WRAP;
  assign start_idx = addr[OFS-1:3];
  always_ff @(posedge clk) begin
    if (reset) begin
      crit_valid <= 1'b0;
      crit_data <= '0;
    end else begin
      crit_valid <= accept && !wr && beat == '0;
      if (accept && !wr && beat == '0) crit_data <= cresp.data;
    end
  end
`else
  localparam logic [ADDR_W-1:0] ADDR_MASK = LINE_MASK;
  localparam logic [1:0] RD_BURST = BURST_INCR;
  assign start_idx = '0;
  assign crit_valid = 1'b0;
  assign crit_data = '0;
`endif
  assign line_addr = addr & ~LINE_MASK;
  assign accept = state == BUSY && cresp.ready;
  assign cmd_ready = state == IDLE;
  assign done = state == FIN;
  assign rline = rbuf;
  always_comb begin
    creq = '0;
    if (state == BUSY) begin
      creq.valid = 1'b1;
      creq.is_write = wr;
      creq.size = 3'd3;
      creq.len = 8'(LINE_WORDS-1);
      creq.addr = 64'(wr ? line_addr : addr);
      creq.burst = wr ? BURST_INCR : RD_BURST;
      creq.data = wr ? wline[beat] : '0;
      creq.strobe = wr ? 8'hff : 8'h00;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      wr <= 1'b0;
      addr <= '0;
      wline <= '0;
      rbuf <= '0;
    end else begin
      state <= state == IDLE ? (cmd_valid ? BUSY : IDLE)
             : state == BUSY ? (accept && cresp.last ? FIN : BUSY) : IDLE;
      if (state == IDLE && cmd_valid) begin
        beat <= '0;
        wr <= cmd_write;
        addr <= cmd_addr & ~ADDR_MASK;
        wline <= cmd_wline;
      end
      if (accept) begin
        if (!wr) rbuf[start_idx + beat] <= cresp.data;
        if (beat != IW'(LINE_WORDS-1)) beat <= beat + 1'b1;
      end
    end
  end
endmodule
